// File: rtl/add_subt_norm_ctrl.sv
// rtl/add_subt_norm_ctrl.sv - normalization sequencer for the FP add/subtract datapath
// Optional LZA misprediction correction (CHECK/CORRECT states) enabled by LZA_CORRECTION_EN.
module add_subt_norm_ctrl #(
    parameter int SWR = 55,
    parameter int EW  = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          add_ovf_i,
    input  logic [EW-1:0] exp_i,
    input  logic [EW-1:0] lza_shift_i,
    input  logic          sig_msb_i,
    output logic          ready_o,
    output logic          load_lza_o,
    output logic          load_shift_o,
    output logic          shift_dir_o,
    output logic [EW-1:0] shift_amt_o,
    output logic [EW-1:0] exp_o,
    output logic          zero_o,
    output logic          underflow_o,
    output logic          overflow_o,
    output logic          done_o
);

    typedef enum logic [2:0] {
        IDLE,
        OVF_SHIFT,
        LZA_LOAD,
        EVAL,
        SHIFT,
`ifdef LZA_CORRECTION_EN
        CHECK,
        CORRECT,
`endif
        DONE
    } state_t;

    localparam logic [EW-1:0] SWR_W   = EW'(SWR);
    localparam logic [EW-1:0] ONE_W   = EW'(1);
    localparam logic [EW-1:0] EXP_MAX = {EW{1'b1}};

    state_t        state_q;
    logic [EW-1:0] exp_q;
    logic          ready_q;
    logic          load_lza_q;
    logic          load_shift_q;
    logic          shift_dir_q;
    logic [EW-1:0] shift_amt_q;
    logic [EW-1:0] exp_o_q;
    logic          zero_q;
    logic          underflow_q;
    logic          overflow_q;
    logic          done_q;

`ifndef LZA_CORRECTION_EN
    logic unused_sig_msb;
    assign unused_sig_msb = sig_msb_i;
`endif

    // All outputs are registered and reflect the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            exp_q        <= '0;
            ready_q      <= 1'b1;
            load_lza_q   <= 1'b0;
            load_shift_q <= 1'b0;
            shift_dir_q  <= 1'b0;
            shift_amt_q  <= '0;
            exp_o_q      <= '0;
            zero_q       <= 1'b0;
            underflow_q  <= 1'b0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            load_lza_q   <= 1'b0;
            load_shift_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (start_i) begin
                        exp_q       <= exp_i;
                        exp_o_q     <= '0;
                        zero_q      <= 1'b0;
                        underflow_q <= 1'b0;
                        overflow_q  <= 1'b0;
                        ready_q     <= 1'b0;
                        if (add_ovf_i) begin
                            state_q      <= OVF_SHIFT;
                            load_shift_q <= 1'b1;
                            shift_dir_q  <= 1'b1;
                            shift_amt_q  <= ONE_W;
                        end else begin
                            state_q    <= LZA_LOAD;
                            load_lza_q <= 1'b1;
                        end
                    end
                end
                OVF_SHIFT: begin
                    // exp_q >= 2^EW-2 would reach or pass the all-ones exponent.
                    if (exp_q >= EXP_MAX - ONE_W) begin
                        exp_o_q    <= EXP_MAX;
                        overflow_q <= 1'b1;
                    end else begin
                        exp_o_q <= exp_q + ONE_W;
                    end
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                LZA_LOAD: begin
                    state_q <= EVAL;
                end
                EVAL: begin
                    shift_dir_q <= 1'b0;
                    if (lza_shift_i >= SWR_W) begin
                        zero_q      <= 1'b1;
                        exp_o_q     <= '0;
                        shift_amt_q <= '0;
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                    end else if (lza_shift_i >= exp_q) begin
                        underflow_q  <= 1'b1;
                        shift_amt_q  <= exp_q;
                        exp_o_q      <= '0;
                        state_q      <= SHIFT;
                        load_shift_q <= 1'b1;
                    end else begin
                        shift_amt_q  <= lza_shift_i;
                        exp_o_q      <= exp_q - lza_shift_i;
                        state_q      <= SHIFT;
                        load_shift_q <= 1'b1;
                    end
                end
                SHIFT: begin
`ifdef LZA_CORRECTION_EN
                    if (!underflow_q) begin
                        state_q <= CHECK;
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
`else
                    state_q <= DONE;
                    done_q  <= 1'b1;
`endif
                end
`ifdef LZA_CORRECTION_EN
                CHECK: begin
                    if (sig_msb_i) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (exp_o_q > ONE_W) begin
                        state_q      <= CORRECT;
                        load_shift_q <= 1'b1;
                        shift_dir_q  <= 1'b0;
                        shift_amt_q  <= ONE_W;
                        exp_o_q      <= exp_o_q - ONE_W;
                    end else begin
                        underflow_q <= 1'b1;
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                    end
                end
                CORRECT: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o      = ready_q;
    assign load_lza_o   = load_lza_q;
    assign load_shift_o = load_shift_q;
    assign shift_dir_o  = shift_dir_q;
    assign shift_amt_o  = shift_amt_q;
    assign exp_o        = exp_o_q;
    assign zero_o       = zero_q;
    assign underflow_o  = underflow_q;
    assign overflow_o   = overflow_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_add_subt_norm_ctrl.sv
// tb/tb_add_subt_norm_ctrl.sv - directed self-checking bench for add_subt_norm_ctrl
module tb_add_subt_norm_ctrl;

    localparam int SWR = 55;
    localparam int EW  = 11;
`ifdef LZA_CORRECTION_EN
    localparam bit CORR = 1'b1;
`else
    localparam bit CORR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          add_ovf_i = 1'b0;
    logic [EW-1:0] exp_i = '0;
    logic [EW-1:0] lza_shift_i = '0;
    logic          sig_msb_i = 1'b0;
    logic          ready_o, load_lza_o, load_shift_o, shift_dir_o;
    logic [EW-1:0] shift_amt_o, exp_o;
    logic          zero_o, underflow_o, overflow_o, done_o;

    int checks = 0;
    int failures = 0;

    int            nlza, nls, ndone, done_cyc;
    logic [EW-1:0] amt1, amt2, r_exp, exp_after;
    logic          dir1, dir2, r_zero, r_uf, r_ovf, rdy1, rdy_after;

    add_subt_norm_ctrl #(.SWR(SWR), .EW(EW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .add_ovf_i(add_ovf_i),
        .exp_i(exp_i), .lza_shift_i(lza_shift_i), .sig_msb_i(sig_msb_i),
        .ready_o(ready_o), .load_lza_o(load_lza_o), .load_shift_o(load_shift_o),
        .shift_dir_o(shift_dir_o), .shift_amt_o(shift_amt_o), .exp_o(exp_o),
        .zero_o(zero_o), .underflow_o(underflow_o), .overflow_o(overflow_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Stimulus/recorder: starts one operation and records strobes, done cycle and results.
    task automatic run_op(input logic ovf, input logic [EW-1:0] e,
                          input logic [EW-1:0] lza, input logic msb);
        nlza = 0; nls = 0; ndone = 0; done_cyc = 0;
        amt1 = '0; amt2 = '0; dir1 = 1'b0; dir2 = 1'b0;
        r_exp = '0; r_zero = 1'b0; r_uf = 1'b0; r_ovf = 1'b0;
        rdy1 = 1'b1; rdy_after = 1'b0; exp_after = '0;
        start_i = 1'b1; add_ovf_i = ovf; exp_i = e; lza_shift_i = lza; sig_msb_i = msb;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) rdy1 = ready_o;
            if (done_cyc != 0 && c == done_cyc + 1) begin
                rdy_after = ready_o;
                exp_after = exp_o;
                break;
            end
            if (load_lza_o) nlza++;
            if (load_shift_o) begin
                if (nls == 0) begin amt1 = shift_amt_o; dir1 = shift_dir_o; end
                else begin amt2 = shift_amt_o; dir2 = shift_dir_o; end
                nls++;
            end
            if (done_o) begin
                ndone++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    r_exp = exp_o; r_zero = zero_o; r_uf = underflow_o; r_ovf = overflow_o;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        checks++; if ({load_lza_o, load_shift_o, shift_dir_o, done_o} !== 4'b0) begin failures++;
            $display("FAIL reset_strobes got=%b exp=0000", {load_lza_o, load_shift_o, shift_dir_o, done_o}); end
        checks++; if ({shift_amt_o, exp_o} !== '0) begin failures++;
            $display("FAIL reset_amt_exp got=%0d/%0d exp=0/0", shift_amt_o, exp_o); end
        checks++; if ({zero_o, underflow_o, overflow_o} !== 3'b0) begin failures++;
            $display("FAIL reset_flags got=%b exp=000", {zero_o, underflow_o, overflow_o}); end
        rst = 1'b0;
    endtask

    task automatic test_carry_out();
        run_op(1'b1, 11'd1023, 11'd0, 1'b1);
        checks++; if (rdy1 !== 1'b0) begin failures++; $display("FAIL carry_ready_drop got=%b exp=0", rdy1); end
        checks++; if (done_cyc !== 2) begin failures++; $display("FAIL carry_done_cycle got=%0d exp=2", done_cyc); end
        checks++; if (nls !== 1 || nlza !== 0 || dir1 !== 1'b1 || amt1 !== 11'd1) begin failures++;
            $display("FAIL carry_shift got nls=%0d nlza=%0d dir=%b amt=%0d exp 1/0/1/1", nls, nlza, dir1, amt1); end
        checks++; if (r_exp !== 11'd1024 || {r_zero, r_uf, r_ovf} !== 3'b0) begin failures++;
            $display("FAIL carry_result got exp=%0d flags=%b exp 1024/000", r_exp, {r_zero, r_uf, r_ovf}); end
        checks++; if (rdy_after !== 1'b1 || exp_after !== 11'd1024) begin failures++;
            $display("FAIL carry_hold got rdy=%b exp=%0d exp 1/1024", rdy_after, exp_after); end
    endtask

    task automatic test_overflow();
        run_op(1'b1, 11'd2046, 11'd0, 1'b1);
        checks++; if (r_exp !== 11'd2047 || r_ovf !== 1'b1 || done_cyc !== 2) begin failures++;
            $display("FAIL ovf_2046 got exp=%0d ovf=%b done=%0d exp 2047/1/2", r_exp, r_ovf, done_cyc); end
        run_op(1'b1, 11'd2045, 11'd0, 1'b1);
        checks++; if (r_exp !== 11'd2046 || r_ovf !== 1'b0) begin failures++;
            $display("FAIL ovf_2045 got exp=%0d ovf=%b exp 2046/0", r_exp, r_ovf); end
    endtask

    task automatic test_lza_exact();
        run_op(1'b0, 11'd1023, 11'd5, 1'b1);
        checks++; if (nlza !== 1 || nls !== 1 || dir1 !== 1'b0 || amt1 !== 11'd5) begin failures++;
            $display("FAIL exact_shift got nlza=%0d nls=%0d dir=%b amt=%0d exp 1/1/0/5", nlza, nls, dir1, amt1); end
        checks++; if (r_exp !== 11'd1018 || {r_zero, r_uf, r_ovf} !== 3'b0) begin failures++;
            $display("FAIL exact_result got exp=%0d flags=%b exp 1018/000", r_exp, {r_zero, r_uf, r_ovf}); end
        checks++; if (done_cyc !== (CORR ? 5 : 4) || ndone !== 1) begin failures++;
            $display("FAIL exact_done got cyc=%0d n=%0d exp %0d/1", done_cyc, ndone, CORR ? 5 : 4); end
    endtask

    task automatic test_lza_off_by_one();
        run_op(1'b0, 11'd1023, 11'd5, 1'b0);
        checks++; if (nls !== (CORR ? 2 : 1) || amt1 !== 11'd5) begin failures++;
            $display("FAIL obo_nshift got nls=%0d amt1=%0d exp %0d/5", nls, amt1, CORR ? 2 : 1); end
        checks++; if (CORR && (amt2 !== 11'd1 || dir2 !== 1'b0)) begin failures++;
            $display("FAIL obo_corr_shift got amt=%0d dir=%b exp 1/0", amt2, dir2); end
        checks++; if (r_exp !== (CORR ? 11'd1017 : 11'd1018) || done_cyc !== (CORR ? 6 : 4)) begin failures++;
            $display("FAIL obo_result got exp=%0d done=%0d exp %0d/%0d", r_exp, done_cyc,
                     CORR ? 1017 : 1018, CORR ? 6 : 4); end
        // exp_o lands on 1 and MSB stays clear: correction must flag underflow instead.
        run_op(1'b0, 11'd6, 11'd5, 1'b0);
        checks++; if (r_exp !== 11'd1 || r_uf !== CORR || nls !== 1 || done_cyc !== (CORR ? 5 : 4)) begin failures++;
            $display("FAIL check_uf got exp=%0d uf=%b nls=%0d done=%0d exp 1/%b/1/%0d", r_exp, r_uf, nls,
                     done_cyc, CORR, CORR ? 5 : 4); end
    endtask

    task automatic test_zero();
        run_op(1'b0, 11'd1023, 11'd55, 1'b1);
        checks++; if (r_zero !== 1'b1 || r_exp !== 11'd0 || nls !== 0 || done_cyc !== 3) begin failures++;
            $display("FAIL zero_55 got zero=%b exp=%0d nls=%0d done=%0d exp 1/0/0/3", r_zero, r_exp, nls, done_cyc); end
        run_op(1'b0, 11'd1023, 11'd54, 1'b1);
        checks++; if (r_zero !== 1'b0 || r_exp !== 11'd969 || amt1 !== 11'd54) begin failures++;
            $display("FAIL zero_54 got zero=%b exp=%0d amt=%0d exp 0/969/54", r_zero, r_exp, amt1); end
    endtask

    task automatic test_underflow();
        run_op(1'b0, 11'd12, 11'd20, 1'b0);
        checks++; if (r_uf !== 1'b1 || r_exp !== 11'd0 || amt1 !== 11'd12 || nls !== 1) begin failures++;
            $display("FAIL uf_result got uf=%b exp=%0d amt=%0d nls=%0d exp 1/0/12/1", r_uf, r_exp, amt1, nls); end
        checks++; if (done_cyc !== 4) begin failures++; $display("FAIL uf_done got=%0d exp=4", done_cyc); end
    endtask

    task automatic test_reset_mid_op();
        start_i = 1'b1; add_ovf_i = 1'b0; exp_i = 11'd1023; lza_shift_i = 11'd5; sig_msb_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (ready_o !== 1'b1 || load_shift_o !== 1'b0 || done_o !== 1'b0) begin failures++;
            $display("FAIL midrst_ctrl got rdy=%b ls=%b done=%b exp 1/0/0", ready_o, load_shift_o, done_o); end
        checks++; if (exp_o !== 11'd0 || shift_amt_o !== 11'd0) begin failures++;
            $display("FAIL midrst_regs got exp=%0d amt=%0d exp 0/0", exp_o, shift_amt_o); end
        rst = 1'b0;
        run_op(1'b0, 11'd100, 11'd3, 1'b1);
        checks++; if (r_exp !== 11'd97 || done_cyc !== (CORR ? 5 : 4)) begin failures++;
            $display("FAIL midrst_after got exp=%0d done=%0d exp 97/%0d", r_exp, done_cyc, CORR ? 5 : 4); end
    endtask

    task automatic test_back_to_back();
        run_op(1'b1, 11'd10, 11'd0, 1'b1);
        run_op(1'b0, 11'd40, 11'd2, 1'b1);
        checks++; if (r_exp !== 11'd38 || r_ovf !== 1'b0 || nlza !== 1) begin failures++;
            $display("FAIL b2b_second got exp=%0d ovf=%b nlza=%0d exp 38/0/1", r_exp, r_ovf, nlza); end
    endtask

    initial begin
        test_reset();
        test_carry_out();
        test_overflow();
        test_lza_exact();
        test_lza_off_by_one();
        test_zero();
        test_underflow();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_subt_norm_ctrl.md
# add_subt_norm_ctrl

Sequencer for the normalization stage of the floating-point add/subtract datapath. After the significand adder settles, it either issues a one-bit right shift on carry-out or strobes the LZA output register, reads the anticipated shift, and drives the barrel shifter and exponent adjustment. With correction enabled, it also fixes the LZA's one-position misprediction, then flags zero, underflow or overflow and pulses `done_o`.

## Interface
- `SWR`, 55: significand working width (26 for single precision).
- `EW`, 11: exponent width (8 for single precision).

Ports (`name` · direction · width · meaning):
- `clk` · in · 1 · clock.
- `rst` · in · 1 · reset; synchronous, active-high.
- `start_i` · in · 1 · adder result valid; accepted only while `ready_o`=1.
- `add_ovf_i` · in · 1 · significand adder carry-out, sampled with `start_i`.
- `exp_i` · in · EW · biased exponent of the larger operand, sampled with `start_i`.
- `lza_shift_i` · in · EW · registered LZA shift value.
- `sig_msb_i` · in · 1 · MSB of the barrel shifter output, used in CHECK.
- `ready_o` · out · 1 · controller idle.
- `load_lza_o` · out · 1 · load strobe for the LZA output register.
- `load_shift_o` · out · 1 · load strobe for the barrel shifter output register.
- `shift_dir_o` · out · 1 · 0 = left, 1 = right.
- `shift_amt_o` · out · EW · shift amount.
- `exp_o` · out · EW · adjusted exponent.
- `zero_o`, `underflow_o`, `overflow_o` · out · 1 each · result flags.
- `done_o` · out · 1 · one-cycle completion pulse.

## Operation
States: IDLE, OVF_SHIFT, LZA_LOAD, EVAL, SHIFT, CHECK, CORRECT, DONE.

**Reset and IDLE**
- Reset forces IDLE on the next edge, including mid-operation.
- Reset values: `ready_o`=1; all other outputs 0.
- IDLE: `ready_o`=1. When `start_i`=1:
  - register `exp_i` into `exp_q`;
  - clear all flags and `exp_o`;
  - if `add_ovf_i`=1, go to OVF_SHIFT, else go to LZA_LOAD.

**Overflow path**
- OVF_SHIFT: `load_shift_o`=1, `shift_dir_o`=1, `shift_amt_o`=1.
- Exponent update: `exp_o`=`exp_q`+1.
- If `exp_q` ≥ 2^EW−2, set `exp_o`=2^EW−1 and `overflow_o`=1.
- Next state: DONE.

**LZA path**
- LZA_LOAD: `load_lza_o`=1 for exactly one cycle. Next state: EVAL.
- EVAL: compare s=`lza_shift_i` against `exp_q`, first match wins.
  1. s ≥ SWR: `zero_o`=1, `exp_o`=0, `shift_amt_o`=0. Next state: DONE (no shift).
  2. s ≥ `exp_q`: `underflow_o`=1, `shift_amt_o`=`exp_q`, `exp_o`=0. Next state: SHIFT.
  3. Otherwise: `shift_amt_o`=s, `exp_o`=`exp_q`−s. Next state: SHIFT.
- `shift_dir_o`=0 for all three cases.
- SHIFT: `load_shift_o`=1.
  - Next state is CHECK if the correction feature is compiled in and `underflow_o`=0.
  - Otherwise next state is DONE.

**Correction path**
- CHECK:
  - `sig_msb_i`=1: go to DONE.
  - `sig_msb_i`=0 and `exp_o` > 1: go to CORRECT.
  - `sig_msb_i`=0 and `exp_o` ≤ 1: set `underflow_o`=1, go to DONE.
- CORRECT: `load_shift_o`=1, `shift_dir_o`=0, `shift_amt_o`=1, `exp_o`−=1. Next state: DONE.

**DONE and output holding**
- DONE: `done_o`=1. Next state: IDLE.
- `exp_o` and the flags hold until the next accepted `start_i`.
- `start_i` outside IDLE is ignored; there is no queueing.

**Arithmetic**
- All exponent arithmetic is unsigned, EW bits wide.
- EVAL guarantees no wrap-around.

## Timing
- `start_i` sampled at edge 0.
- Overflow path: OVF_SHIFT in cycle 1; `done_o` in cycle 2.
- LZA path: LZA_LOAD in cycle 1; `lza_shift_i` is valid in cycle 2 (EVAL); SHIFT in cycle 3.
- `done_o` cycle by path:
  - with correction and no correction needed: cycle 5;
  - with correction applied: cycle 6;
  - macro absent, or underflow: cycle 4;
  - zero result: cycle 3.
- Strobes (`load_lza_o`, `load_shift_o`, `done_o`) are Moore outputs, high for exactly one cycle per visit.
- `shift_amt_o` and `shift_dir_o` are registered and stable through the `load_shift_o` cycle.
- `ready_o` drops the cycle after acceptance. The earliest next start is the cycle after DONE.

## Configuration
- `LZA_CORRECTION_EN` defined: the CHECK and CORRECT states exist, and `sig_msb_i` is used.
- `LZA_CORRECTION_EN` undefined: SHIFT goes directly to DONE, `sig_msb_i` is ignored, and the CHECK/CORRECT encodings are absent.

## Test plan
All cases use SWR=55, EW=11, macro defined.
- **Carry-out:** `add_ovf_i`=1, `exp_i`=1023 → right shift by 1, `exp_o`=1024, `done_o` at cycle 2, no flags.
- **Overflow:** `add_ovf_i`=1, `exp_i`=2046 → `exp_o`=2047, `overflow_o`=1.
- **LZA exact:** `exp_i`=1023, `lza_shift_i`=5, `sig_msb_i`=1 → left shift by 5, `exp_o`=1018, `done_o` at cycle 5.
- **LZA off by one:** same as above but `sig_msb_i`=0 in CHECK → extra left shift by 1, `exp_o`=1017, `done_o` at cycle 6.
- **Zero result:** `lza_shift_i`=55 → `zero_o`=1, `exp_o`=0, no `load_shift_o`.
- **Underflow:** `lza_shift_i`=20, `exp_i`=12 → shift by 12, `exp_o`=0, `underflow_o`=1.
- **Reset mid-operation:** `rst` asserted in EVAL → IDLE and reset values next cycle; a following start completes normally.
